// File: rtl/ps2_scancode_ctrl.sv
// rtl/ps2_scancode_ctrl.sv - PS/2 Set-2 prefix sequencer with FWFT event FIFO and status reporting.
// Optional build macro PS2_SEQ_TIMEOUT_EN adds a prefix-to-code timeout.
module ps2_scancode_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic                          ev_ext,
    output logic                          ev_brk,
    output logic [7:0]                    ev_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          status_valid,
    output logic [7:0]                    status_byte,
    output logic                          overflow,
    output logic                          proto_err,
    input  logic                          clear_status
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    state_t          state_q, state_d, cur_state;
    logic            rx_valid_q, rx_valid_d;
    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [9:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            status_valid_q, status_valid_d;
    logic [7:0]      status_byte_q, status_byte_d;
    logic            overflow_q, overflow_d;
    logic            proto_err_q, proto_err_d;

    logic            rise, is_pfx, is_sts, is_key, timeout;
    logic            push, do_push, pop, full, err_set, sts_pulse;
    logic [9:0]      push_data, head;

    assign rise   = rx_valid & ~rx_valid_q;
    assign is_pfx = (rx_data == 8'hE0) || (rx_data == 8'hF0);
    assign is_sts = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hEE) ||
                    (rx_data == 8'hFE) || (rx_data == 8'h00) || (rx_data == 8'hFF);
    assign is_key = ~is_pfx & ~is_sts;

`ifdef PS2_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign timeout = (state_q != IDLE) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (state_d == IDLE || rise) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // A timeout in the same cycle as a rise makes the byte start from IDLE.
    assign cur_state = timeout ? IDLE : state_q;

    always_comb begin
        state_d   = cur_state;
        push      = 1'b0;
        push_data = 10'd0;
        err_set   = timeout;
        sts_pulse = 1'b0;
        if (rise) begin
            sts_pulse = is_sts;
            case (cur_state)
                IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state_d = GOT_E0;
                    end else if (rx_data == 8'hF0) begin
                        state_d = GOT_F0;
                    end else if (is_key) begin
                        push      = 1'b1;
                        push_data = {2'b00, rx_data};
                    end
                end
                GOT_E0: begin
                    if (rx_data == 8'hF0) begin
                        state_d = GOT_E0F0;
                    end else if (rx_data == 8'hE0) begin
                        state_d = GOT_E0;
                    end else if (is_key) begin
                        push      = 1'b1;
                        push_data = {2'b10, rx_data};
                        state_d   = IDLE;
                    end else begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end
                end
                GOT_F0: begin
                    state_d = IDLE;
                    if (is_key) begin
                        push      = 1'b1;
                        push_data = {2'b01, rx_data};
                    end else begin
                        err_set = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    if (is_key) begin
                        push      = 1'b1;
                        push_data = {2'b11, rx_data};
                    end else begin
                        err_set = 1'b1;
                    end
                end
            endcase
        end
    end

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = ev_valid & ev_ready;
    assign do_push = push & (~full | pop);

    always_comb begin
        rx_valid_d     = rx_valid;
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q + CW'(do_push) - CW'(pop);
        status_valid_d = sts_pulse;
        status_byte_d  = sts_pulse ? rx_data : status_byte_q;
        overflow_d     = (push & full & ~pop) | (overflow_q & ~clear_status);
        proto_err_d    = err_set | (proto_err_q & ~clear_status);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            rx_valid_q     <= 1'b1;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 10'd0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            status_valid_q <= 1'b0;
            status_byte_q  <= 8'd0;
            overflow_q     <= 1'b0;
            proto_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rx_valid_q     <= rx_valid_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            status_valid_q <= status_valid_d;
            status_byte_q  <= status_byte_d;
            overflow_q     <= overflow_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign ev_valid     = (count_q != '0);
    assign head         = mem_q[rd_ptr_q];
    assign ev_ext       = ev_valid & head[9];
    assign ev_brk       = ev_valid & head[8];
    assign ev_code      = ev_valid ? head[7:0] : 8'd0;
    assign fifo_count   = count_q;
    assign status_valid = status_valid_q;
    assign status_byte  = status_byte_q;
    assign overflow     = overflow_q;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// tb/tb_ps2_scancode_ctrl.sv - scoreboard bench for ps2_scancode_ctrl with a behavioural prefix model.
module tb_ps2_scancode_ctrl;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock, reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          ev_valid, ev_ready, ev_ext, ev_brk;
    logic [7:0]    ev_code;
    logic [CW-1:0] fifo_count;
    logic          status_valid;
    logic [7:0]    status_byte;
    logic          overflow, proto_err, clear_status;

    ps2_scancode_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(100)) dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ext(ev_ext), .ev_brk(ev_brk),
        .ev_code(ev_code), .fifo_count(fifo_count), .status_valid(status_valid),
        .status_byte(status_byte), .overflow(overflow), .proto_err(proto_err),
        .clear_status(clear_status)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [9:0] exp_ev[$];
    logic [7:0] exp_sts[$];
    logic [9:0] got_ev;
    logic [7:0] got_sts;
    int total = 0;
    int bad   = 0;
    bit m_e0, m_f0, m_err, m_ovf;
    bit rnd_ready = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_sts(input logic [7:0] b);
        return b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF;
    endfunction

    // Tracks which prefixes are pending instead of a state machine.
    task automatic model_byte(input logic [7:0] b);
        if (is_sts(b)) begin
            exp_sts.push_back(b);
            if (m_e0 || m_f0) m_err = 1;
            m_e0 = 0; m_f0 = 0;
        end else if (b == 8'hE0 || b == 8'hF0) begin
            if (m_f0) begin
                m_err = 1; m_e0 = 0; m_f0 = 0;
            end else if (b == 8'hE0) begin
                m_e0 = 1;
            end else begin
                m_f0 = 1;
            end
        end else begin
            if (exp_ev.size() >= DEPTH) m_ovf = 1;
            else exp_ev.push_back({m_e0, m_f0, b});
            m_e0 = 0; m_f0 = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            if (rnd_ready) ev_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send(input logic [7:0] b, input int hold, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        model_byte(b);
        tick(hold);
        rx_valid = 1'b0;
        tick(gap);
    endtask

    // Checks one-cycle latency from the rise to ev_valid with an empty-consumer FIFO.
    task automatic send_lat(input logic [7:0] b, input int cnt_before);
        rx_data  = b;
        rx_valid = 1'b1;
        model_byte(b);
        @(negedge clock);
        chk("lat_before", int'(fifo_count), cnt_before);
        @(negedge clock);
        chk("lat_ev_valid", int'(ev_valid), 1);
        chk("lat_count", int'(fifo_count), cnt_before + 1);
        @(posedge clock);
        #1;
        tick(18);
        rx_valid = 1'b0;
        tick(20);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        ev_ready = 1'b1;
        while ((exp_ev.size() != 0 || exp_sts.size() != 0) && n < 300) begin
            tick(1);
            n++;
        end
        tick(2);
        chk({name, "_ev_left"}, exp_ev.size(), 0);
        chk({name, "_sts_left"}, exp_sts.size(), 0);
    endtask

    task automatic do_clear();
        clear_status = 1'b1;
        m_err = 0; m_ovf = 0;
        tick(1);
        clear_status = 1'b0;
        tick(1);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (ev_valid && ev_ready) begin
                total++;
                if (exp_ev.size() == 0) begin
                    bad++;
                    $display("FAIL ev_unexpected: got %h expected none", {ev_ext, ev_brk, ev_code});
                end else begin
                    got_ev = exp_ev.pop_front();
                    if ({ev_ext, ev_brk, ev_code} !== got_ev) begin
                        bad++;
                        $display("FAIL ev_data: got %h expected %h", {ev_ext, ev_brk, ev_code}, got_ev);
                    end
                end
            end
            if (status_valid) begin
                total++;
                if (exp_sts.size() == 0) begin
                    bad++;
                    $display("FAIL sts_unexpected: got %h expected none", status_byte);
                end else begin
                    got_sts = exp_sts.pop_front();
                    if (status_byte !== got_sts) begin
                        bad++;
                        $display("FAIL sts_data: got %h expected %h", status_byte, got_sts);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        int r;
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; ev_ready = 1'b0; clear_status = 1'b0;
        m_e0 = 0; m_f0 = 0; m_err = 0; m_ovf = 0;
        tick(3);
        chk("rst_ev_valid", int'(ev_valid), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_status_valid", int'(status_valid), 0);
        chk("rst_status_byte", int'(status_byte), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_proto_err", int'(proto_err), 0);
        chk("rst_ev_code", int'(ev_code), 0);
        reset = 1'b0;
        tick(2);

        // make and break of the same key, held in the FIFO
        send_lat(8'h1C, 0);
        send(8'hF0, 20, 20);
        send_lat(8'h1C, 1);
        chk("t1_count", int'(fifo_count), 2);
        drain("t1");

        // extended make and break
        send(8'hE0, 3, 3); send(8'h75, 3, 3);
        send(8'hE0, 3, 3); send(8'hF0, 3, 3); send(8'h75, 3, 3);
        drain("t2");
        chk("t2_proto_err", int'(proto_err), 0);

        // status byte, then illegal F0 E0
        send(8'hAA, 3, 3); send(8'hF0, 3, 3); send(8'hE0, 3, 3);
        chk("t3_proto_err", int'(proto_err), int'(m_err));
        chk("t3_no_event", int'(ev_valid), 0);
        send(8'h1C, 3, 3);
        drain("t3");
        do_clear();
        chk("t3_cleared", int'(proto_err), 0);

        // overflow with a stalled consumer; set wins over a coincident clear
        ev_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) send(8'h10 + 8'(i), 2, 2);
        chk("t4_count_full", int'(fifo_count), DEPTH);
        chk("t4_overflow", int'(overflow), 1);
        rx_data = 8'h33; rx_valid = 1'b1; clear_status = 1'b1;
        model_byte(8'h33);
        tick(1);
        clear_status = 1'b0;
        tick(2);
        rx_valid = 1'b0;
        tick(2);
        chk("t4_set_wins", int'(overflow), 1);
        chk("t4_count_hold", int'(fifo_count), DEPTH);
        drain("t4");
        chk("t4_count_empty", int'(fifo_count), 0);
        do_clear();
        chk("t4_cleared", int'(overflow), 0);

        // reset release with rx_valid held, and reset mid-sequence
        reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h1C;
        tick(2);
        reset = 1'b0;
        m_e0 = 0; m_f0 = 0; m_err = 0; m_ovf = 0;
        tick(20);
        rx_valid = 1'b0;
        tick(5);
        chk("t5_no_event", int'(ev_valid), 0);
        send(8'hE0, 3, 3);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        m_e0 = 0; m_f0 = 0;
        tick(2);
        send(8'h75, 3, 3);
        drain("t5");
        chk("t5_proto_err", int'(proto_err), 0);

`ifdef PS2_SEQ_TIMEOUT_EN
        send(8'hE0, 3, 0);
        tick(150);
        m_err = 1; m_e0 = 0; m_f0 = 0;
        chk("t6_proto_err", int'(proto_err), 1);
        send(8'h75, 3, 3);
        drain("t6");
        do_clear();
`endif

        // randomized byte stream with a randomly stalling consumer
        rnd_ready = 1;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = ($urandom_range(0, 1) != 0) ? 8'hFA : 8'hAA;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send(b, $urandom_range(1, 4), $urandom_range(1, 4));
        end
        rnd_ready = 0;
        drain("rnd");
        chk("rnd_proto_err", int'(proto_err), int'(m_err));
        chk("rnd_overflow", int'(overflow), int'(m_ovf));
        chk("rnd_count", int'(fifo_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
